// File: rtl/sdram_pkg.sv
// Shared definitions for the 16-bit SDR SDRAM pin interface: command
// encodings, violation codes and the per-bank tracking record.
package sdram_pkg;

   // {cs, ras, cas, we}, all active low
   localparam logic [3:0] CMD_DESELECT     = 4'b1111;
   localparam logic [3:0] CMD_NOP          = 4'b0111;
   localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
   localparam logic [3:0] CMD_READ         = 4'b0101;
   localparam logic [3:0] CMD_WRITE        = 4'b0100;
   localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
   localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
   localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;
   localparam logic [3:0] CMD_BURST_TERM   = 4'b0110;

   typedef enum logic [3:0] {
      SD_DESELECT     = CMD_DESELECT,
      SD_NOP          = CMD_NOP,
      SD_ACTIVE       = CMD_ACTIVE,
      SD_READ         = CMD_READ,
      SD_WRITE        = CMD_WRITE,
      SD_PRECHARGE    = CMD_PRECHARGE,
      SD_AUTO_REFRESH = CMD_AUTO_REFRESH,
      SD_LOAD_MODE    = CMD_LOAD_MODE,
      SD_BURST_TERM   = CMD_BURST_TERM
   } sdram_cmd_t;

   localparam logic [2:0] ERR_NONE         = 3'd0;
   localparam logic [2:0] ERR_BANK_OPEN    = 3'd1;
   localparam logic [2:0] ERR_BANK_CLOSED  = 3'd2;
   localparam logic [2:0] ERR_TRCD         = 3'd3;
   localparam logic [2:0] ERR_TRP          = 3'd4;
   localparam logic [2:0] ERR_MODE         = 3'd5;
   localparam logic [2:0] ERR_REFRESH_OPEN = 3'd6;
   localparam logic [2:0] ERR_CONTENTION   = 3'd7;

   typedef struct packed {
      logic        open;
      logic [11:0] row;
      logic [3:0]  age;
   } bank_state_t;

   typedef struct packed {
      logic        valid;
      logic [1:0]  mask;
      logic [15:0] data;
   } rd_slot_t;

   function automatic sdram_cmd_t decode_cmd(input logic [3:0] strobes);
      sdram_cmd_t cmd;
      cmd = SD_NOP;
      if (strobes[3]) begin
         cmd = SD_DESELECT;
      end else begin
         case (strobes[2:0])
            3'b111:  cmd = SD_NOP;
            3'b011:  cmd = SD_ACTIVE;
            3'b101:  cmd = SD_READ;
            3'b100:  cmd = SD_WRITE;
            3'b010:  cmd = SD_PRECHARGE;
            3'b001:  cmd = SD_AUTO_REFRESH;
            3'b000:  cmd = SD_LOAD_MODE;
            default: cmd = SD_BURST_TERM;
         endcase
      end
      return cmd;
   endfunction

   // Several violations in one command report the smallest code.
   function automatic logic [2:0] lowest_err(input logic [7:1] viol);
      logic [2:0] code;
      code = ERR_NONE;
      for (int i = 7; i >= 1; i--) begin
         if (viol[i]) code = 3'(i);
      end
      return code;
   endfunction

endpackage

// File: rtl/sdram_resp_ram.sv
// Single-port synchronous backing RAM, 16-bit words with two byte enables;
// kept apart so vendor block-RAM inference sees a plain template.
module sdram_resp_ram #(
   parameter int ADDR_W = 12
) (
   input  logic              clk_i,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [1:0]        be_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [15:0]       wdata_i,
   output logic [15:0]       rdata_o
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [15:0] mem_q [DEPTH];
   logic [15:0] rdata_q;

   // NOTE: the array and its read register have no reset, so synthesis can map
   // them onto block RAM; contents survive srst_n_i.
   // NOTE: clocked state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
            if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_responder.sv
// SDR SDRAM device emulator: decodes controller commands, tracks banks and
// mode, stores writes, returns reads after the CAS latency, flags violations.
module sdram_responder
   import sdram_pkg::*;
#(
   parameter int MEM_ADDR_W = 12,
   parameter int TRCD       = 3,
   parameter int TRP        = 2
) (
   input  logic        clk_i,
   input  logic        srst_n_i,
   inout  wire  [15:0] dq_io,
   input  logic [11:0] a_i,
   input  logic [1:0]  bs_i,
   input  logic [1:0]  dqm_i,
   input  logic        cs_i,
   input  logic        ras_i,
   input  logic        cas_i,
   input  logic        we_i,
   input  logic        cke_i,
   output logic        mode_valid_o,
   output logic [1:0]  cas_lat_o,
   output logic        err_o,
   output logic [2:0]  err_code_o,
   output logic [15:0] refresh_cnt_o
);

   localparam int         NBANK  = 4;
   localparam logic [4:0] TRCD_C = 5'(TRCD);
   localparam logic [4:0] TRP_C  = 5'(TRP);

   bank_state_t bank_q [NBANK];
   bank_state_t bank_d [NBANK];
   logic        mode_valid_q, mode_valid_d;
   logic [1:0]  cas_lat_q, cas_lat_d;
   logic        err_q, err_d;
   logic [2:0]  err_code_q, err_code_d;
   logic [15:0] refresh_cnt_q, refresh_cnt_d;
   logic        rd0_valid_q, rd0_valid_d;
   logic [1:0]  rd0_mask_q, rd0_mask_d;
   rd_slot_t    pipe1_q, pipe1_d, pipe2_q, pipe2_d;

   sdram_cmd_t            cmd;
   bank_state_t           sel;
   logic [4:0]            sel_elapsed;
   logic [7:1]            viol;
   logic                  any_open;
   logic                  rw_ok;
   logic                  ram_en, ram_we;
   logic [1:0]            ram_be;
   logic [MEM_ADDR_W-1:0] ram_addr;
   logic [15:0]           ram_rdata;
   rd_slot_t              dq_slot;
   logic                  dq_oe;

   // Age is 0 right after the ACTIVE/PRECHARGE edge, so a command k edges
   // later sees age k-1; this returns k (saturating with the counter).
   function automatic logic [4:0] elapsed(input logic [3:0] age);
      return {1'b0, age} + 5'd1;
   endfunction

   assign dq_slot = (cas_lat_q == 2'd2) ? pipe1_q : pipe2_q;
   assign dq_oe   = dq_slot.valid && (dq_slot.mask != 2'b11);
   assign dq_io   = dq_oe ? dq_slot.data : 'z;

   sdram_resp_ram #(.ADDR_W(MEM_ADDR_W)) u_ram (
      .clk_i   (clk_i),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .be_i    (ram_be),
      .addr_i  (ram_addr),
      .wdata_i (dq_io),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      // NOTE: every signal written here gets a default first, so no branch can infer a latch.
      cmd           = cke_i ? decode_cmd({cs_i, ras_i, cas_i, we_i}) : SD_NOP;
      sel           = bank_q[bs_i];
      sel_elapsed   = elapsed(sel.age);
      any_open      = 1'b0;
      viol          = '0;
      rw_ok         = 1'b0;
      mode_valid_d  = mode_valid_q;
      cas_lat_d     = cas_lat_q;
      refresh_cnt_d = refresh_cnt_q;
      ram_en        = 1'b0;
      ram_we        = 1'b0;
      ram_be        = ~dqm_i;
      ram_addr      = MEM_ADDR_W'({bs_i, sel.row, a_i[7:0]});
      rd0_valid_d   = 1'b0;
      rd0_mask_d    = dqm_i;
      for (int b = 0; b < NBANK; b++) begin
         any_open  = any_open | bank_q[b].open;
         bank_d[b] = bank_q[b];
         if (bank_q[b].age != 4'hF) bank_d[b].age = bank_q[b].age + 4'd1;
      end

      case (cmd)
         SD_LOAD_MODE: begin
            if (any_open || (a_i[6:4] != 3'd2 && a_i[6:4] != 3'd3) || a_i[2:0] != 3'b000) begin
               viol[ERR_MODE] = 1'b1;
            end else begin
               cas_lat_d    = a_i[5:4];
               mode_valid_d = 1'b1;
            end
         end
         SD_ACTIVE: begin
            if (sel.open) begin
               viol[ERR_BANK_OPEN] = 1'b1;
            end else if (sel_elapsed < TRP_C) begin
               viol[ERR_TRP] = 1'b1;
            end else begin
               bank_d[bs_i].open = 1'b1;
               bank_d[bs_i].row  = a_i;
               bank_d[bs_i].age  = 4'd0;
            end
         end
         SD_READ, SD_WRITE: begin
            viol[ERR_BANK_CLOSED] = !sel.open;
            viol[ERR_TRCD]        = sel_elapsed < TRCD_C;
            viol[ERR_MODE]        = !mode_valid_q;
            rw_ok = !(viol[ERR_BANK_CLOSED] || viol[ERR_TRCD] || viol[ERR_MODE]);
            if (rw_ok) begin
               ram_en = 1'b1;
               if (cmd == SD_WRITE) begin
                  ram_we               = 1'b1;
                  viol[ERR_CONTENTION] = dq_oe;
               end else begin
                  rd0_valid_d = 1'b1;
               end
               if (a_i[10]) begin
                  bank_d[bs_i].open = 1'b0;
                  bank_d[bs_i].age  = 4'd0;
               end
            end
         end
         SD_PRECHARGE: begin
            for (int b = 0; b < NBANK; b++) begin
               if (a_i[10] || bs_i == 2'(b)) begin
                  bank_d[b].open = 1'b0;
                  bank_d[b].age  = 4'd0;
               end
            end
         end
         SD_AUTO_REFRESH: begin
            viol[ERR_REFRESH_OPEN] = any_open;
            for (int b = 0; b < NBANK; b++) begin
               if (!bank_q[b].open && elapsed(bank_q[b].age) < TRP_C) viol[ERR_TRP] = 1'b1;
            end
            if (viol == '0 && refresh_cnt_q != 16'hFFFF) refresh_cnt_d = refresh_cnt_q + 16'd1;
         end
         default: ;
      endcase

      err_d      = |viol;
      err_code_d = err_d ? lowest_err(viol) : err_code_q;
   end

   // Masked read bytes go out as zero; a fully masked slot never enables dq.
   always_comb begin
      pipe1_d.valid = rd0_valid_q;
      pipe1_d.mask  = rd0_mask_q;
      pipe1_d.data  = {rd0_mask_q[1] ? 8'h00 : ram_rdata[15:8],
                       rd0_mask_q[0] ? 8'h00 : ram_rdata[7:0]};
      pipe2_d       = pipe1_q;
   end

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         for (int b = 0; b < NBANK; b++) begin
            bank_q[b] <= '{open: 1'b0, row: 12'h000, age: 4'hF};
         end
         mode_valid_q  <= 1'b0;
         cas_lat_q     <= 2'd3;
         err_q         <= 1'b0;
         err_code_q    <= ERR_NONE;
         refresh_cnt_q <= 16'h0000;
         rd0_valid_q   <= 1'b0;
         rd0_mask_q    <= 2'b00;
         pipe1_q       <= '0;
         pipe2_q       <= '0;
      end else begin
         bank_q        <= bank_d;
         mode_valid_q  <= mode_valid_d;
         cas_lat_q     <= cas_lat_d;
         err_q         <= err_d;
         err_code_q    <= err_code_d;
         refresh_cnt_q <= refresh_cnt_d;
         rd0_valid_q   <= rd0_valid_d;
         rd0_mask_q    <= rd0_mask_d;
         pipe1_q       <= pipe1_d;
         pipe2_q       <= pipe2_d;
      end
   end

   assign mode_valid_o  = mode_valid_q;
   assign cas_lat_o     = cas_lat_q;
   assign err_o         = err_q;
   assign err_code_o    = err_code_q;
   assign refresh_cnt_o = refresh_cnt_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: commands are driven just after each rising edge,
// read data is checked from a scoreboard on the falling edge it is due.
module tb_sdram_responder;
   import sdram_pkg::*;

   // A released bus floats high through the pullups.
   localparam logic [15:0] DQ_IDLE = 16'hFFFF;

   logic        clk = 1'b0;
   logic        srst_n;
   logic [11:0] a;
   logic [1:0]  bs, dqm;
   logic        cs, ras, cas, we, cke;
   logic        mode_valid, err;
   logic [1:0]  cas_lat;
   logic [2:0]  err_code;
   logic [15:0] refresh_cnt;
   logic [15:0] tb_dq;
   logic        tb_dq_en;
   wire  [15:0] dq;

   always #5 clk = ~clk;

   assign dq = tb_dq_en ? tb_dq : 'z;
   for (genvar g = 0; g < 16; g++) begin : g_pull
      pullup u_pu (dq[g]);
   end

   sdram_responder u_dut (
      .clk_i         (clk),
      .srst_n_i      (srst_n),
      .dq_io         (dq),
      .a_i           (a),
      .bs_i          (bs),
      .dqm_i         (dqm),
      .cs_i          (cs),
      .ras_i         (ras),
      .cas_i         (cas),
      .we_i          (we),
      .cke_i         (cke),
      .mode_valid_o  (mode_valid),
      .cas_lat_o     (cas_lat),
      .err_o         (err),
      .err_code_o    (err_code),
      .refresh_cnt_o (refresh_cnt)
   );

   typedef struct {
      int          due;
      logic [15:0] data;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_bad  = 0;
   int   cyc    = 0;
   int   cl     = 3;
   logic mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check(e.tag, dq, e.data);
         end else if (!tb_dq_en) begin
            check("idle_bus", dq, DQ_IDLE);
         end
      end
   end

   task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [11:0] addr,
                        input logic [1:0] m, input logic drive, input logic [15:0] d);
      {cs, ras, cas, we} = c;
      bs       = b;
      a        = addr;
      dqm      = m;
      tb_dq_en = drive;
      tb_dq    = d;
      @(posedge clk);
      #1;
      {cs, ras, cas, we} = CMD_NOP;
      tb_dq_en = 1'b0;
      dqm      = 2'b00;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write(input logic [1:0] b, input logic [7:0] col, input logic [1:0] m,
                        input logic [15:0] d);
      issue(CMD_WRITE, b, {4'h0, col}, m, 1'b1, d);
   endtask

   // Data is due on the falling edge just before rising edge N+cl.
   task automatic read(input logic [1:0] b, input logic [7:0] col, input logic [1:0] m,
                       input logic [15:0] exp, input string tag);
      issue(CMD_READ, b, {4'h0, col}, m, 1'b0, 16'h0000);
      sb.push_back('{due: cyc + cl - 1, data: exp, tag: tag});
   endtask

   task automatic status(input string tag, input logic exp_err, input logic [2:0] exp_code);
      check({tag, "_err"}, 16'(err), 16'(exp_err));
      check({tag, "_code"}, 16'(err_code), 16'(exp_code));
   endtask

   task automatic regs(input string tag, input logic exp_mv, input logic [1:0] exp_cl,
                       input logic [15:0] exp_ref);
      check({tag, "_mode_valid"}, 16'(mode_valid), 16'(exp_mv));
      check({tag, "_cas_lat"}, 16'(cas_lat), 16'(exp_cl));
      check({tag, "_refresh"}, refresh_cnt, exp_ref);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      srst_n   = 1'b0;
      cke      = 1'b1;
      {cs, ras, cas, we} = CMD_DESELECT;
      a        = '0;
      bs       = '0;
      dqm      = '0;
      tb_dq    = '0;
      tb_dq_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      srst_n = 1'b1;
      mon_en = 1'b1;
      regs("reset", 1'b0, 2'd3, 16'd0);
      status("reset", 1'b0, ERR_NONE);

      // Basic write then read at CAS latency 3
      issue(CMD_LOAD_MODE, 2'd0, 12'h030, 2'b00, 1'b0, 16'h0);
      status("lmr_cl3", 1'b0, ERR_NONE);
      regs("lmr_cl3", 1'b1, 2'd3, 16'd0);
      issue(CMD_ACTIVE, 2'd1, 12'h0A5, 2'b00, 1'b0, 16'h0);
      status("act_b1", 1'b0, ERR_NONE);
      idle(3);
      write(2'd1, 8'h10, 2'b00, 16'hBEEF);
      status("wr_beef", 1'b0, ERR_NONE);
      read(2'd1, 8'h10, 2'b00, 16'hBEEF, "rd_beef_cl3");
      status("rd_beef", 1'b0, ERR_NONE);
      idle(4);

      // Back-to-back reads at CAS latency 2
      issue(CMD_PRECHARGE, 2'd0, 12'h400, 2'b00, 1'b0, 16'h0);
      status("pre_all", 1'b0, ERR_NONE);
      issue(CMD_LOAD_MODE, 2'd0, 12'h020, 2'b00, 1'b0, 16'h0);
      cl = 2;
      status("lmr_cl2", 1'b0, ERR_NONE);
      regs("lmr_cl2", 1'b1, 2'd2, 16'd0);
      idle(2);
      issue(CMD_ACTIVE, 2'd0, 12'h000, 2'b00, 1'b0, 16'h0);
      status("act_b0", 1'b0, ERR_NONE);
      idle(3);
      for (int i = 0; i < 4; i++) write(2'd0, 8'(i), 2'b00, 16'(i + 1));
      for (int i = 0; i < 4; i++) read(2'd0, 8'(i), 2'b00, 16'(i + 1), "rd_b2b");
      idle(4);

      // Byte masks on write and on read
      write(2'd0, 8'h20, 2'b00, 16'hFFFF);
      write(2'd0, 8'h20, 2'b10, 16'h1234);
      read(2'd0, 8'h20, 2'b00, 16'hFF34, "rd_wmask");
      read(2'd0, 8'h20, 2'b01, 16'hFF00, "rd_rmask_lo");
      read(2'd0, 8'h20, 2'b11, DQ_IDLE, "rd_rmask_all");
      idle(4);

      // Closed bank, one-cycle error pulse, tRCD, double ACTIVE
      read(2'd2, 8'h00, 2'b00, DQ_IDLE, "rd_closed_z");
      status("rd_closed", 1'b1, ERR_BANK_CLOSED);
      idle(1);
      status("err_pulse", 1'b0, ERR_BANK_CLOSED);
      issue(CMD_ACTIVE, 2'd2, 12'h005, 2'b00, 1'b0, 16'h0);
      status("act_b2", 1'b0, ERR_BANK_CLOSED);
      read(2'd2, 8'h00, 2'b00, DQ_IDLE, "rd_trcd_z");
      status("rd_trcd", 1'b1, ERR_TRCD);
      issue(CMD_ACTIVE, 2'd0, 12'h000, 2'b00, 1'b0, 16'h0);
      status("act_open", 1'b1, ERR_BANK_OPEN);
      idle(4);

      // Refresh with open banks, then after precharge-all plus tRP
      issue(CMD_AUTO_REFRESH, 2'd0, 12'h000, 2'b00, 1'b0, 16'h0);
      status("ref_open", 1'b1, ERR_REFRESH_OPEN);
      regs("ref_open", 1'b1, 2'd2, 16'd0);
      issue(CMD_PRECHARGE, 2'd0, 12'h400, 2'b00, 1'b0, 16'h0);
      idle(2);
      repeat (3) begin
         issue(CMD_AUTO_REFRESH, 2'd0, 12'h000, 2'b00, 1'b0, 16'h0);
         status("ref_ok", 1'b0, ERR_REFRESH_OPEN);
      end
      regs("ref_3", 1'b1, 2'd2, 16'd3);

      // Reset in the cycle after a READ cancels its data
      issue(CMD_ACTIVE, 2'd3, 12'h000, 2'b00, 1'b0, 16'h0);
      idle(3);
      read(2'd3, 8'h00, 2'b00, DQ_IDLE, "rd_reset_z");
      srst_n = 1'b0;
      @(posedge clk);
      #1;
      srst_n = 1'b1;
      cl = 3;
      regs("post_rst", 1'b0, 2'd3, 16'd0);
      status("post_rst", 1'b0, ERR_NONE);
      read(2'd3, 8'h00, 2'b00, DQ_IDLE, "rd_after_rst_z");
      status("rd_after_rst", 1'b1, ERR_BANK_CLOSED);
      issue(CMD_LOAD_MODE, 2'd0, 12'h070, 2'b00, 1'b0, 16'h0);
      status("lmr_bad", 1'b1, ERR_MODE);
      regs("lmr_bad", 1'b0, 2'd3, 16'd0);
      idle(6);

      check("sb_drained", 16'(sb.size()), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
Synthesizable SDRAM device emulator, the responder side of the 16-bit SDR SDRAM pin interface that the board memory controller drives.
- Decodes cs/ras/cas/we commands, tracks per-bank open rows and the mode register, and stores writes into on-chip RAM.
- Returns read data on dq after the programmed CAS latency.
- Used for FPGA loopback tests and fast simulation of the controller without the vendor model.
- Flags protocol and timing violations.

Parameters:
MEM_ADDR_W, 12, backing RAM depth is 2^MEM_ADDR_W words; store index is the low MEM_ADDR_W bits of {bank[1:0], row[11:0], col[7:0]}.
TRCD, 3, minimum clocks from ACTIVE to READ/WRITE on the same bank.
TRP, 2, minimum clocks from PRECHARGE to ACTIVE/AUTO_REFRESH.

Ports:
clk_i  in  1  clock; same clock as the SDRAM clock.
srst_n_i  in  1  synchronous reset, active low.
dq_io  inout  16  data bus; driven only while dq_oe is high, else 'z.
a_i  in  12  address.
bs_i  in  2  bank select.
dqm_i  in  2  byte mask; bit1 = dq[15:8], bit0 = dq[7:0].
cs_i, ras_i, cas_i, we_i  in  1 each  command strobes, active low.
cke_i  in  1  clock enable.
mode_valid_o  out  1  mode register has been loaded.
cas_lat_o  out  2  programmed CAS latency (2 or 3).
err_o  out  1  one-cycle pulse on any violation.
err_code_o  out  3  cause of the last violation; held until the next violation.
refresh_cnt_o  out  16  AUTO_REFRESH count; saturates at 16'hFFFF.

Behaviour:
Reset:
- Reset is synchronous and active low; clock is clk_i.
- Reset values: mode_valid_o=0, cas_lat_o=3, err_o=0, err_code_o=0, refresh_cnt_o=0, all banks closed, read pipeline empty, dq released.
- RAM contents are not cleared.
- Reset mid-read cancels pending data; dq is released the next cycle.

Command decode:
- Strobes are registered on each rising edge. Decode {cs,ras,cas,we}: 1xxx DESELECT, 0111 NOP, 0011 ACTIVE, 0101 READ, 0100 WRITE, 0010 PRECHARGE, 0001 AUTO_REFRESH, 0000 LOAD_MODE, 0110 BURST_TERM (treated as NOP).
- cke_i low: command treated as NOP; pipeline keeps advancing.

Per-bank state (4 banks):
- Each bank holds open flag, row[11:0], and a saturating 4-bit age counter.
- Age counter is cleared on ACTIVE or PRECHARGE and increments every cycle.

Command behaviour:
- LOAD_MODE: requires all banks closed.
  - a_i[6:4] = 2 or 3 sets cas_lat_o; any other value gives err code 5 and leaves the latency unchanged.
  - a_i[2:0] must be 0 (burst 1), else code 5.
  - mode_valid_o = 1 after a legal load.
- ACTIVE: bank already open -> code 1, ignored. Age < TRP since PRECHARGE -> code 4, ignored. Otherwise open the bank with row = a_i.
- READ/WRITE:
  - Bank closed -> code 2.
  - Age < TRCD -> code 3.
  - mode_valid_o = 0 -> code 5.
  - On any of these the command is ignored.
  - Column = a_i[7:0]. a_i[10]=1 closes the bank after the access (auto precharge), and its age restarts.
- WRITE: dq_io is sampled in the same cycle. Byte lanes are written where the dqm bit is 0; dqm=2'b11 writes nothing.
- READ: data for a READ sampled at edge N is driven so it is valid at edge N+cas_lat_o.
  - Synchronous RAM read plus shift register of depth 3, holding valid, data and mask.
  - dqm_i sampled with the READ: a masked byte is driven as 8'h00; dqm=2'b11 keeps dq released for that slot.
  - Back-to-back READs each cycle return data on consecutive cycles.
- PRECHARGE: a_i[10]=1 closes all banks, else bank bs_i. Precharging a closed bank is legal and silent.
- AUTO_REFRESH: any bank open -> code 6, no count. Otherwise refresh_cnt_o += 1, saturating.
- Bus contention: WRITE accepted in a cycle where read data is being driven -> code 7. The write still occurs with the sampled value.

Error reporting:
- Multiple violations in one cycle: the lowest code is reported.
- err_o is high for exactly one cycle per offending command.

Decomposition:
- Package sdram_pkg:
  - Command encoding localparams (DESELECT … LOAD_MODE), shared with the controller.
  - Typedef sdram_cmd_t enum, err code localparams.
  - Typedef bank_state_t struct {open, row[11:0], age[3:0]}.
- Sub-module sdram_resp_ram: parameterized single-port synchronous RAM, 16-bit, with 2-bit byte enable, so vendor RAM inference is isolated.

Test Plan:
- Reset, LOAD_MODE a=12'h030, ACTIVE bank1 row 12'h0A5, wait 3, WRITE col 8'h10 dq=16'hBEEF dqm=0, READ col 8'h10 -> dq=16'hBEEF exactly 3 clocks after READ; mode_valid_o=1, no err.
- LOAD_MODE CL=2, READs on 4 consecutive cycles to cols 0..3 (prefilled 1,2,3,4) -> dq shows 1,2,3,4 on consecutive cycles starting 2 clocks after the first READ.
- WRITE 16'h1234 dqm=2'b10 over 16'hFFFF -> read back 16'hFF34; READ with dqm=2'b01 -> 16'hFF00.
- READ to a closed bank -> err_o pulse, err_code_o=2, dq stays 'z. ACTIVE then READ after 1 clock -> code 3.
- AUTO_REFRESH with bank0 open -> code 6, count 0. After PRECHARGE a[10]=1 plus TRP clocks, 3 refreshes -> refresh_cnt_o=3.
- Drop srst_n_i in the cycle after a READ -> no data driven, banks closed, mode_valid_o=0. LOAD_MODE a=12'h070 -> code 5, cas_lat_o stays 3.
